// File: rtl/izh_neuron_scheduler_if.sv
// Link between the neuron scheduler and the shared combinational Izhikevich update unit.
// The scheduler presents one neuron's state; the update unit answers in the same cycle.
interface izh_neuron_scheduler_if;
    logic [15:0] dp_v;
    logic [15:0] dp_u;
    logic [15:0] dp_i;
    logic [15:0] dp_v_next;
    logic [15:0] dp_u_next;
    logic        dp_spike;

    modport master (
        output dp_v, dp_u, dp_i,
        input  dp_v_next, dp_u_next, dp_spike
    );

    modport slave (
        input  dp_v, dp_u, dp_i,
        output dp_v_next, dp_u_next, dp_spike
    );
endinterface

// File: rtl/izh_neuron_scheduler.sv
// Time-multiplexes one Izhikevich update unit over N_NEURONS virtual neurons,
// holding v/u/I banks locally and sweeping every neuron once per start.
module izh_neuron_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int IDX_W     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    cur_wr_en,
    input  logic [IDX_W-1:0]        cur_wr_idx,
    input  logic [15:0]             cur_wr_data,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [15:0]             rd_v,
    output logic [15:0]             rd_u,
    izh_neuron_scheduler_if.master  dp,
    output logic                    busy,
    output logic                    done,
    output logic                    spike_valid,
    output logic [IDX_W-1:0]        spike_idx,
    output logic [N_NEURONS-1:0]    spike_vec,
    output logic [15:0]             step_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q;
    logic [15:0]            v_q [N_NEURONS];
    logic [15:0]            u_q [N_NEURONS];
    logic [15:0]            i_q [N_NEURONS];
    logic [N_NEURONS-1:0]   spike_vec_q;
    logic [15:0]            step_count_q;
    logic                   spike_valid_q;
    logic [IDX_W-1:0]       spike_idx_q;
    logic                   run_s;
    logic [IDX_W-1:0]       sel_s;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE, so it is never queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
                else       state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (idx_q == LAST_IDX) state_d = ST_DONE;
                else                   state_d = ST_RUN;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode; outside RUN the update unit sees neuron 0 and its results are dropped.
    always_comb begin
        run_s = 1'b0;
        done  = 1'b0;
        case (state_q)
            ST_RUN:  run_s = 1'b1;
            ST_DONE: done  = 1'b1;
            default: begin
                run_s = 1'b0;
                done  = 1'b0;
            end
        endcase
        busy     = run_s;
        sel_s    = run_s ? idx_q : {IDX_W{1'b0}};
        dp.dp_v  = v_q[sel_s];
        dp.dp_u  = u_q[sel_s];
        dp.dp_i  = i_q[sel_s];
        rd_v     = v_q[rd_idx];
        rd_u     = u_q[rd_idx];
    end

    // Sweep index, spike bookkeeping and step counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q         <= {IDX_W{1'b0}};
            spike_vec_q   <= {N_NEURONS{1'b0}};
            step_count_q  <= 16'h0000;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= {IDX_W{1'b0}};
        end else begin
            if (state_q == ST_IDLE && start) begin
                idx_q       <= {IDX_W{1'b0}};
                spike_vec_q <= {N_NEURONS{1'b0}};
            end else if (run_s) begin
                idx_q              <= idx_q + IDX_W'(1);
                spike_vec_q[idx_q] <= dp.dp_spike;
            end
            if (state_q == ST_DONE) begin
                step_count_q <= step_count_q + 16'd1;
            end
            spike_valid_q <= run_s & dp.dp_spike;
            spike_idx_q   <= idx_q;
        end
    end

    // State and current banks; a current write lands at the edge, so the cycle that
    // is sweeping the same neuron still uses the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                v_q[k] <= 16'h0000;
                u_q[k] <= 16'h0000;
                i_q[k] <= 16'h0000;
            end
        end else begin
            if (run_s) begin
                v_q[idx_q] <= dp.dp_v_next;
                u_q[idx_q] <= dp.dp_u_next;
            end
            if (cur_wr_en) begin
                i_q[cur_wr_idx] <= cur_wr_data;
            end
        end
    end

    assign spike_vec   = spike_vec_q;
    assign step_count  = step_count_q;
    assign spike_valid = spike_valid_q;
    assign spike_idx   = spike_idx_q;

endmodule
